// File: rtl/hyp_sched.sv
// Two-requester round-robin hypotenuse engine, floor(sqrt(x^2+y^2)) via shift-add squaring + restoring root.
// Result 3W+1 edges after accept; held in DONE until res_ready, no new requests accepted meanwhile.
module hyp_sched #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_x,
    input  logic [W-1:0] req0_y,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_x,
    input  logic [W-1:0] req1_y,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W:0]   res_data,
    output logic         res_id,
    output logic         busy
);
    // sum padded to an even width so the root consumes exactly two bits per step
    localparam int SW = 2 * W + 2;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {IDLE, SQX, SQY, ROOT, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [W-1:0]  op_x, op_y, op_cur, op_shr;
    logic [SW-1:0] sum, rem, rem_sh, trial, addend;
    logic [W:0]    root, root_nx;
    logic          cur_id, last_grant;
    logic          grant0, grant1, accept, rem_ge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant0   = 1'b0;
        grant1   = 1'b0;
        case (state)
            IDLE: begin
                grant0 = req0_valid && (!req1_valid || last_grant);
                grant1 = req1_valid && (!req0_valid || !last_grant);
                if (grant0 || grant1) state_nx = SQX;
            end
            SQX:     if (cnt == CW'(W - 1)) state_nx = SQY;
            SQY:     if (cnt == CW'(W - 1)) state_nx = ROOT;
            ROOT:    if (cnt == CW'(W))     state_nx = DONE;
            DONE:    if (res_ready)         state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign busy       = (state != IDLE);

    // squaring step: add op<<cnt when bit cnt of the operand is set
    assign op_cur = (state == SQX) ? op_x : op_y;
    assign op_shr = op_cur >> cnt;
    assign addend = {{(SW - W){1'b0}}, op_cur} << cnt;

    // root step: bring down the next two radicand bits, try (2*root)*2+1
    assign rem_sh  = {rem[SW-3:0], sum[SW-1:SW-2]};
    assign trial   = {{(SW - W - 3){1'b0}}, root, 2'b01};
    assign rem_ge  = (rem_sh >= trial);
    assign root_nx = {root[W-1:0], rem_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            op_x       <= '0;
            op_y       <= '0;
            sum        <= '0;
            rem        <= '0;
            root       <= '0;
            cur_id     <= 1'b0;
            last_grant <= 1'b1;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_x       <= grant1 ? req1_x : req0_x;
                        op_y       <= grant1 ? req1_y : req0_y;
                        cur_id     <= grant1;
                        last_grant <= grant1;
                        sum        <= '0;
                        rem        <= '0;
                        root       <= '0;
                        cnt        <= '0;
                    end
                end
                SQX, SQY: begin
                    if (op_shr[0]) sum <= sum + addend;
                    cnt <= (cnt == CW'(W - 1)) ? '0 : cnt + CW'(1);
                end
                ROOT: begin
                    rem  <= rem_ge ? (rem_sh - trial) : rem_sh;
                    root <= root_nx;
                    sum  <= sum << 2;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(W)) begin
                        res_data  <= root_nx;
                        res_id    <= cur_id;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hyp_sched.sv
// Scoreboarded bench for hyp_sched: arbitration, latency, hold under backpressure, reset abort, random sweep.
module tb_hyp_sched;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_x, req0_y, req1_x, req1_y;
    logic         res_valid, res_ready, res_id, busy;
    logic [W:0]   res_data;

    always #5 clk = ~clk;

    hyp_sched #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
        .busy(busy)
    );

    typedef struct {
        int data;
        int id;
        int acc;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic       tb_last = 1'b1;
    logic       tb_idle = 1'b1;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [W:0] prev_data = '0;
    logic       prev_id = 1'b0;
    logic       e0, e1;
    int         ex, ey;
    logic [W-1:0] fx0, fy0, fx1, fy1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int isqrt(input int s);
        int r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            e0 = tb_idle && req0_valid && (!req1_valid || tb_last);
            e1 = tb_idle && req1_valid && (!req0_valid || !tb_last);
            chk("req0_ready", int'(req0_ready), int'(e0));
            chk("req1_ready", int'(req1_ready), int'(e1));
            chk("busy", int'(busy), int'(!tb_idle));
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", int'(res_valid), 1);
                chk("hold_data", int'(res_data), int'(prev_data));
                chk("hold_id", int'(res_id), int'(prev_id));
            end
            if (res_valid && !prev_valid) begin
                chk("result_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) chk("latency", cyc - sb[0].acc, 3 * W + 1);
            end
            if (res_valid && res_ready) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("res_data", int'(res_data), e.data);
                    chk("res_id", int'(res_id), e.id);
                end
                tb_idle = 1'b1;
            end
            if (e0 || e1) begin
                ex = e1 ? int'(req1_x) : int'(req0_x);
                ey = e1 ? int'(req1_y) : int'(req0_y);
                e.data = isqrt(ex * ex + ey * ey);
                e.id   = int'(e1);
                e.acc  = cyc + 1;
                sb.push_back(e);
                tb_last = e1;
                tb_idle = 1'b0;
            end
            prev_valid = res_valid;
            prev_ready = res_ready;
            prev_data  = res_data;
            prev_id    = res_id;
        end
    end

    // drives both ports until n0/n1 requests are accepted and all results drained
    task automatic run_ports(input int n0, input int n1, input bit rnd);
        int left0 = n0;
        int left1 = n1;
        int guard = 0;
        int lim = 400 + 80 * (n0 + n1);
        bit acc0, acc1;
        while ((left0 > 0 || left1 > 0 || sb.size() > 0 || !tb_idle) && guard < lim) begin
            @(negedge clk);
            acc0 = req0_ready;
            acc1 = req1_ready;
            @(posedge clk);
            #1;
            guard++;
            if (acc0) begin left0--; req0_valid = 1'b0; end
            if (acc1) begin left1--; req1_valid = 1'b0; end
            if (rnd) begin
                if (req0_valid && $urandom_range(0, 15) == 0) req0_valid = 1'b0;
                if (req1_valid && $urandom_range(0, 15) == 0) req1_valid = 1'b0;
                res_ready = 1'($urandom_range(0, 1));
            end
            if (!req0_valid && left0 > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                req0_valid = 1'b1;
                req0_x = rnd ? W'($urandom_range(0, 255)) : fx0;
                req0_y = rnd ? W'($urandom_range(0, 255)) : fy0;
            end
            if (!req1_valid && left1 > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                req1_valid = 1'b1;
                req1_x = rnd ? W'($urandom_range(0, 255)) : fx1;
                req1_y = rnd ? W'($urandom_range(0, 255)) : fy1;
            end
        end
        chk("run_timeout", int'(guard < lim), 1);
        res_ready = 1'b1;
    endtask

    task automatic wait_grant0();
        int g = 0;
        bit ok = 1'b0;
        while (!ok && g < 60) begin
            @(negedge clk);
            ok = req0_ready;
            g++;
        end
        chk("grant0_timeout", int'(ok), 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() > 0 || !tb_idle) && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_timeout", int'(g < 200), 1);
    endtask

    int cx[4]   = '{255, 0, 1, 255};
    int cy[4]   = '{255, 0, 1, 0};
    int cexp[4] = '{360, 0, 1, 255};

    initial begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
        res_ready = 1'b1;
        fx0 = '0; fy0 = '0; fx1 = '0; fy1 = '0;

        #3 rst_n = 1'b0;
        #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // single request on port 0
        fx0 = 8'd3; fy0 = 8'd4;
        run_ports(1, 0, 1'b0);
        chk("basic_3_4", int'(res_data), 5);

        // corner operands on port 1
        for (int i = 0; i < 4; i++) begin
            fx1 = W'(cx[i]); fy1 = W'(cy[i]);
            run_ports(0, 1, 1'b0);
            chk("corner_data", int'(res_data), cexp[i]);
            chk("corner_id", int'(res_id), 1);
        end

        // both ports contending continuously
        fx0 = 8'd6; fy0 = 8'd8; fx1 = 8'd5; fy1 = 8'd12;
        run_ports(2, 2, 1'b0);

        // backpressure in DONE with port 1 waiting
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_x = 8'd3; req0_y = 8'd4;
        wait_grant0();
        req1_valid = 1'b1; req1_x = 8'd5; req1_y = 8'd12;
        begin
            int g = 0;
            while (!res_valid && g < 60) begin @(negedge clk); g++; end
            chk("bp_result_timeout", int'(res_valid), 1);
        end
        repeat (10) begin
            @(negedge clk);
            chk("bp_data", int'(res_data), 5);
            chk("bp_id", int'(res_id), 0);
            chk("bp_busy", int'(busy), 1);
            chk("bp_req1_ready", int'(req1_ready), 0);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_busy", int'(busy), 0);
        chk("bp_idle_valid", int'(res_valid), 0);
        chk("bp_next_grant", int'(req1_ready), 1);
        @(posedge clk);
        #1 req1_valid = 1'b0;
        drain();

        // reset during ROOT aborts the operation
        req0_valid = 1'b1; req0_x = 8'd100; req0_y = 8'd200;
        wait_grant0();
        repeat (20) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_res_valid", int'(res_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_res_data", int'(res_data), 0);
        sb.delete();
        tb_idle = 1'b1;
        tb_last = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        fx0 = 8'd8; fy0 = 8'd15;
        run_ports(1, 0, 1'b0);
        chk("after_reset_8_15", int'(res_data), 17);

        // random sweep on both ports
        run_ports(500, 500, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
